// File: rtl/fm_demod_stream.sv
// fm_demod_stream: multi-channel FM discriminator, angle(s[n]*conj(s[n-1]))*gain via iterative CORDIC.
// Build option: define DEMOD_SAT_EN to saturate the scaled result instead of wrapping it.
module fm_demod_stream #(
   parameter int  DATA_WIDTH   = 32,
   parameter int  FRAC_BITS    = 10,
   parameter int  CORDIC_ITERS = 14,
   parameter int  NUM_CH       = 1,
   localparam int CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [CH_W-1:0]              in_ch,
   input  logic signed [DATA_WIDTH-1:0] in_x,
   input  logic signed [DATA_WIDTH-1:0] in_y,
   input  logic signed [DATA_WIDTH-1:0] gain,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [CH_W-1:0]              out_ch,
   output logic signed [DATA_WIDTH-1:0] out_demod
);
   localparam int  PW  = 2 * DATA_WIDTH;
   localparam int  K_W = (CORDIC_ITERS > 1) ? $clog2(CORDIC_ITERS) : 1;
   localparam int  NH  = 2 ** CH_W;
   localparam real SCL = 2.0 ** FRAC_BITS;
   localparam logic signed [DATA_WIDTH-1:0] PI_Q = DATA_WIDTH'($rtoi(3.141592653589793 * SCL + 0.5));
`ifdef DEMOD_SAT_EN
   localparam logic signed [DATA_WIDTH-1:0] MAX_Q = {1'b0, {(DATA_WIDTH-1){1'b1}}};
   localparam logic signed [DATA_WIDTH-1:0] MIN_Q = {1'b1, {(DATA_WIDTH-1){1'b0}}};
`endif

   typedef enum logic [2:0] {IDLE, MULT, ROTATE, SCALE, OUT} state_t;

   function automatic real atan_real(input int k);
      case (k)
         0:       return 0.7853981633974483;
         1:       return 0.4636476090008061;
         2:       return 0.24497866312686414;
         3:       return 0.12435499454676144;
         4:       return 0.06241880999595735;
         5:       return 0.031239833430268277;
         6:       return 0.015623728620476831;
         7:       return 0.007812341060101111;
         8:       return 0.0039062301319669718;
         9:       return 0.0019531225164788188;
         10:      return 0.0009765621895593195;
         11:      return 0.0004882812111948983;
         12:      return 0.00024414062014936177;
         13:      return 0.00012207031189367021;
         14:      return 0.00006103515617420877;
         15:      return 0.000030517578115526096;
         default: return 1.0 / (2.0 ** k);
      endcase
   endfunction

   // Floor shift back to Q(FRAC_BITS), keeping the low DATA_WIDTH bits.
   function automatic logic signed [DATA_WIDTH-1:0] q_trunc(input logic signed [PW-1:0] prod);
      return DATA_WIDTH'(prod >>> FRAC_BITS);
   endfunction

   function automatic logic signed [DATA_WIDTH-1:0] scale_out(input logic signed [PW-1:0] prod);
`ifdef DEMOD_SAT_EN
      logic signed [PW-1:0] sh;
      sh = prod >>> FRAC_BITS;
      if (sh > PW'(MAX_Q)) return MAX_Q;
      if (sh < PW'(MIN_Q)) return MIN_Q;
`endif
      return q_trunc(prod);
   endfunction

   state_t                       state_q, state_d;
   logic [K_W-1:0]               k_q, k_d;
   logic [CH_W-1:0]              ch_q, ch_d, out_ch_q, out_ch_d;
   logic signed [DATA_WIDTH-1:0] x_q, x_d, y_q, y_d, gain_q, gain_d, xp_q, xp_d, yp_q, yp_d;
   logic signed [DATA_WIDTH-1:0] r_q, r_d, i_q, i_d, z_q, z_d, out_demod_q, out_demod_d;
   logic                         zero_q, zero_d;
   logic signed [DATA_WIDTH-1:0] hist_x_q [NH];
   logic signed [DATA_WIDTH-1:0] hist_x_d [NH];
   logic signed [DATA_WIDTH-1:0] hist_y_q [NH];
   logic signed [DATA_WIDTH-1:0] hist_y_d [NH];
   logic signed [DATA_WIDTH-1:0] atan_tab [2**K_W];
   logic signed [PW-1:0]         re_p, im_p, sc_p;
   logic signed [DATA_WIDTH-1:0] r_m, i_m, r_sh, i_sh, z_eff;
   logic                         ch_ok;

   for (genvar g = 0; g < 2**K_W; g++) begin : g_atan
      localparam int AQ = $rtoi(atan_real(g) * SCL + 0.5);
      assign atan_tab[g] = DATA_WIDTH'(AQ);
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == OUT);
   assign out_ch    = out_ch_q;
   assign out_demod = out_demod_q;

   always_comb begin
      state_d     = state_q;
      k_d         = k_q;
      ch_d        = ch_q;
      out_ch_d    = out_ch_q;
      x_d         = x_q;
      y_d         = y_q;
      gain_d      = gain_q;
      xp_d        = xp_q;
      yp_d        = yp_q;
      r_d         = r_q;
      i_d         = i_q;
      z_d         = z_q;
      zero_d      = zero_q;
      out_demod_d = out_demod_q;
      hist_x_d    = hist_x_q;
      hist_y_d    = hist_y_q;
      re_p        = '0;
      im_p        = '0;
      sc_p        = '0;
      r_m         = '0;
      i_m         = '0;
      r_sh        = '0;
      i_sh        = '0;
      z_eff       = '0;
      ch_ok       = ({1'b0, in_ch} < (CH_W+1)'(NUM_CH));
      unique case (state_q)
         IDLE: begin
            // Out-of-range channel tags are consumed here and dropped.
            if (in_valid && ch_ok) begin
               x_d             = in_x;
               y_d             = in_y;
               gain_d          = gain;
               ch_d            = in_ch;
               xp_d            = hist_x_q[in_ch];
               yp_d            = hist_y_q[in_ch];
               hist_x_d[in_ch] = in_x;
               hist_y_d[in_ch] = in_y;
               state_d         = MULT;
            end
         end
         MULT: begin
            re_p   = PW'(x_q) * PW'(xp_q) + PW'(y_q) * PW'(yp_q);
            im_p   = PW'(y_q) * PW'(xp_q) - PW'(x_q) * PW'(yp_q);
            r_m    = q_trunc(re_p);
            i_m    = q_trunc(im_p);
            zero_d = (r_m == '0) && (i_m == '0);
            // Fold the left half-plane onto the right so CORDIC only has to cover +-pi/2.
            if (r_m[DATA_WIDTH-1]) begin
               r_d = -r_m;
               i_d = -i_m;
               z_d = (!i_m[DATA_WIDTH-1]) ? PI_Q : -PI_Q;
            end else begin
               r_d = r_m;
               i_d = i_m;
               z_d = '0;
            end
            k_d     = '0;
            state_d = ROTATE;
         end
         ROTATE: begin
            r_sh = r_q >>> k_q;
            i_sh = i_q >>> k_q;
            if (!i_q[DATA_WIDTH-1]) begin
               r_d = r_q + i_sh;
               i_d = i_q - r_sh;
               z_d = z_q + atan_tab[k_q];
            end else begin
               r_d = r_q - i_sh;
               i_d = i_q + r_sh;
               z_d = z_q - atan_tab[k_q];
            end
            k_d = k_q + K_W'(1);
            if (k_q == K_W'(CORDIC_ITERS - 1)) state_d = SCALE;
         end
         SCALE: begin
            z_eff       = zero_q ? '0 : z_q;
            sc_p        = PW'(gain_q) * PW'(z_eff);
            out_demod_d = scale_out(sc_p);
            out_ch_d    = ch_q;
            state_d     = OUT;
         end
         OUT: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         k_q         <= '0;
         out_ch_q    <= '0;
         out_demod_q <= '0;
         for (int c = 0; c < NH; c++) begin
            hist_x_q[c] <= '0;
            hist_y_q[c] <= '0;
         end
      end else begin
         state_q     <= state_d;
         k_q         <= k_d;
         out_ch_q    <= out_ch_d;
         out_demod_q <= out_demod_d;
         hist_x_q    <= hist_x_d;
         hist_y_q    <= hist_y_d;
      end
   end

   always_ff @(posedge clock) begin
      ch_q   <= ch_d;
      x_q    <= x_d;
      y_q    <= y_d;
      gain_q <= gain_d;
      xp_q   <= xp_d;
      yp_q   <= yp_d;
      r_q    <= r_d;
      i_q    <= i_d;
      z_q    <= z_d;
      zero_q <= zero_d;
   end
endmodule

// File: tb/tb_fm_demod_stream.sv
// Bench for fm_demod_stream: directed FM discriminator cases plus randomized samples against a reference model.
module tb_fm_demod_stream;
   localparam int F     = 10;
   localparam int ITERS = 14;
   localparam int NCH   = 3;
   localparam int LAT   = ITERS + 2;
   localparam int PI_Q  = 3217;

   logic               clock = 1'b0;
   logic               reset = 1'b1;
   logic               in_valid = 1'b0;
   logic               in_ready;
   logic [1:0]         in_ch = '0;
   logic signed [31:0] in_x = '0;
   logic signed [31:0] in_y = '0;
   logic signed [31:0] gain = '0;
   logic               out_valid;
   logic               out_ready = 1'b0;
   logic [1:0]         out_ch;
   logic signed [31:0] out_demod;

   int n_cmp = 0;
   int n_bad = 0;
   int hx [4];
   int hy [4];

   fm_demod_stream #(.NUM_CH(NCH)) dut (
      .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .in_ch(in_ch), .in_x(in_x), .in_y(in_y), .gain(gain),
      .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch), .out_demod(out_demod)
   );

   always #5 clock = ~clock;

   initial begin
      #2000000;
      $display("FAIL watchdog: time limit reached before summary, required completion");
      $fatal(1, "watchdog");
   end

   // Reference: ideal discriminator math in integers, CORDIC as a plain loop.
   function automatic int atan_q(input int k);
      return $rtoi($atan(2.0 ** (-k)) * 1024.0 + 0.5);
   endfunction

   function automatic int model_angle(input int x, input int y, input int xp, input int yp);
      longint pr, pq;
      int r, i, z, rsh, ish;
      pr = longint'(x) * longint'(xp) + longint'(y) * longint'(yp);
      pq = longint'(y) * longint'(xp) - longint'(x) * longint'(yp);
      r  = int'(pr >>> F);
      i  = int'(pq >>> F);
      z  = 0;
      if (r == 0 && i == 0) return 0;
      if (r < 0) begin
         z = (i >= 0) ? PI_Q : -PI_Q;
         r = -r;
         i = -i;
      end
      for (int k = 0; k < ITERS; k++) begin
         rsh = r >>> k;
         ish = i >>> k;
         if (i >= 0) begin
            r = r + ish; i = i - rsh; z = z + atan_q(k);
         end else begin
            r = r - ish; i = i + rsh; z = z - atan_q(k);
         end
      end
      return z;
   endfunction

   function automatic int model_scale(input int g, input int z);
      longint p;
      p = (longint'(g) * longint'(z)) >>> F;
`ifdef DEMOD_SAT_EN
      if (p > longint'(32'sh7FFFFFFF)) return 32'sh7FFFFFFF;
      if (p < -(longint'(1) <<< 31)) return 32'sh80000000;
`endif
      return int'(p);
   endfunction

   task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp_v);
      n_cmp++;
      assert (obs === exp_v) else begin
         n_bad++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
      end
   endtask

   task automatic chk_near(input string tag, input int obs, input int ideal, input int tol);
      int d;
      d = obs - ideal;
      if (d < 0) d = -d;
      n_cmp++;
      assert (d <= tol) else begin
         n_bad++;
         $error("FAIL %s: observed %0d expected %0d +-%0d", tag, obs, ideal, tol);
      end
   endtask

   task automatic clear_model();
      for (int c = 0; c < 4; c++) begin
         hx[c] = 0;
         hy[c] = 0;
      end
   endtask

   task automatic apply_reset();
      reset = 1'b1;
      clear_model();
      repeat (2) @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
   endtask

   task automatic send(input int ch, input int x, input int y, input int g);
      int n;
      n = 0;
      while (in_ready !== 1'b1 && n < 100) begin
         @(negedge clock);
         n++;
      end
      n_cmp++;
      assert (n < 100) else begin
         n_bad++;
         $error("FAIL send_ready: in_ready low for %0d cycles, expected high", n);
      end
      in_valid = 1'b1;
      in_ch    = 2'(ch);
      in_x     = x;
      in_y     = y;
      gain     = g;
      @(negedge clock);
      in_valid = 1'b0;
   endtask

   task automatic recv(input string tag, input int ech, input int edem, input int hold, output int got);
      int n;
      n = 0;
      while (out_valid !== 1'b1 && n < 100) begin
         @(negedge clock);
         n++;
      end
      chk({tag, "_latency"}, n, LAT);
      chk({tag, "_ch"}, out_ch, ech);
      chk({tag, "_demod"}, out_demod, edem);
      got = out_demod;
      for (int c = 0; c < hold; c++) begin
         @(negedge clock);
         chk({tag, "_hold_valid"}, out_valid, 1);
         chk({tag, "_hold_demod"}, out_demod, edem);
         chk({tag, "_hold_ch"}, out_ch, ech);
         chk({tag, "_hold_in_ready"}, in_ready, 0);
      end
      out_ready = 1'b1;
      @(negedge clock);
      out_ready = 1'b0;
      chk({tag, "_valid_drop"}, out_valid, 0);
      chk({tag, "_in_ready_back"}, in_ready, 1);
   endtask

   task automatic xact(input string tag, input int ch, input int x, input int y, input int g,
                       input int hold, output int got);
      int exp_v, seen;
      got = 0;
      if (ch >= NCH) begin
         send(ch, x, y, g);
         seen = 0;
         repeat (LAT + 4) begin
            @(negedge clock);
            if (out_valid !== 1'b0) seen++;
         end
         chk({tag, "_badch_silent"}, seen, 0);
      end else begin
         exp_v  = model_scale(g, model_angle(x, y, hx[ch], hy[ch]));
         hx[ch] = x;
         hy[ch] = y;
         send(ch, x, y, g);
         recv(tag, ch, exp_v, hold, got);
      end
   endtask

   function automatic int rnd_val();
      case ($urandom_range(0, 3))
         0:       return int'($urandom_range(0, 4095)) - 2048;
         1:       return int'($urandom_range(0, 65535)) - 32768;
         2:       return int'($urandom);
         default: return ($urandom_range(0, 1) == 0) ? 1024 : -1024;
      endcase
   endfunction

   initial begin
      int got;
      clear_model();
      repeat (3) @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      chk("reset_out_valid", out_valid, 0);
      chk("reset_out_ch", out_ch, 0);
      chk("reset_out_demod", out_demod, 0);
      chk("reset_in_ready", in_ready, 1);

      // quarter-turn step
      xact("t1a", 0, 1024, 0, 1024, 0, got);
      chk("t1a_zero", got, 0);
      xact("t1b", 0, 0, 1024, 1024, 0, got);
      chk_near("t1b_pi2", got, 1608, 3);

      // half-turn step lands on +PI
      apply_reset();
      xact("t2a", 0, 1024, 0, 1024, 0, got);
      chk_near("t2a_zero", got, 0, 3);
      xact("t2b", 0, 1024, 0, 1024, 0, got);
      chk_near("t2b_zero", got, 0, 3);
      xact("t2c", 0, -1024, 0, 1024, 0, got);
      chk_near("t2c_pi", got, 3217, 3);
      xact("t2d", 0, 0, -1024, 1024, 0, got);
      chk_near("t2d_pi2", got, 1608, 3);

      // independent channel histories
      apply_reset();
      xact("t3a", 0, 1024, 0, 1024, 0, got);
      xact("t3b", 1, 0, 1024, 1024, 0, got);
      chk_near("t3b_zero", got, 0, 3);
      xact("t3c", 0, 0, 1024, 1024, 0, got);
      chk_near("t3c_pos", got, 1608, 3);
      xact("t3d", 1, 1024, 0, 1024, 0, got);
      chk_near("t3d_neg", got, -1608, 3);

      // backpressure hold
      xact("t4", 0, -1024, 0, 1024, 5, got);

      // out-of-range channel consumed without output or history change
      xact("badch", 3, 777, -555, 1024, 0, got);
      xact("after_badch", 0, 0, 1024, 1024, 0, got);

      // reset during rotation aborts and clears history
      apply_reset();
      send(0, 1024, 0, 1024);
      repeat (5) @(negedge clock);
      reset = 1'b1;
      #1;
      chk("t5_out_valid", out_valid, 0);
      chk("t5_in_ready", in_ready, 1);
      chk("t5_out_demod", out_demod, 0);
      @(negedge clock);
      reset = 1'b0;
      clear_model();
      @(negedge clock);
      xact("t5_after", 0, 0, 1024, 1024, 0, got);
      chk("t5_after_zero", got, 0);

      // large gain on pi/2
      apply_reset();
      xact("t6a", 0, 1024, 0, 1024, 0, got);
      xact("t6b", 0, 0, 1024, 32'sh7FFFFFFF, 0, got);
`ifdef DEMOD_SAT_EN
      chk("t6_sat", got, 32'sh7FFFFFFF);
`endif

      for (int t = 0; t < 40; t++) begin
         int ch, x, y, g;
         ch = int'($urandom_range(0, 3));
         x  = rnd_val();
         y  = rnd_val();
         g  = ($urandom_range(0, 2) == 0) ? int'($urandom) : int'($urandom_range(0, 4095)) - 2048;
         xact("rnd", ch, x, y, g, (t % 7 == 0) ? 2 : 0, got);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
